// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, inverse-SubBytes FSM states, slice count helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Number of slices needed to cover the state with bpc lookups per cycle.
  function automatic int unsigned aes_nslice(input int unsigned bpc);
    return AES_BYTES / bpc;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational FIPS-197 inverse S-box; entry for input x sits at byte x counted from the MSB.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry a lives at bit offset (255-a)*8, i.e. {~a, 3'b000}.
  assign d = INV_SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// Multi-cycle inverse SubBytes: BYTES_PER_CYCLE inverse S-box lookups applied slice by slice in place.
module aes_inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned NSLICE  = aes_nslice(BYTES_PER_CYCLE);
  localparam int unsigned SLICE_W = 8 * BYTES_PER_CYCLE;
  localparam int unsigned CNT_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned NMUX    = 1 << CNT_W;

  aes_state_e             st_q, st_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [SLICE_W-1:0]     slice_arr [NMUX];
  logic [SLICE_W-1:0]     cur_slice;
  logic [SLICE_W-1:0]     sub_slice;
  logic                   last_slice;

  // Slice k covers bytes k*BPC.. (MSB-first); unused mux slots alias real slices.
  for (genvar k = 0; k < NMUX; k++) begin : g_slice
    assign slice_arr[k] = data_q[(NSLICE-1-(k % NSLICE))*SLICE_W +: SLICE_W];
  end

  assign cur_slice  = slice_arr[cnt_q];
  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  // One inverse S-box per byte lane of the current slice.
  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a (cur_slice[(BYTES_PER_CYCLE-1-b)*8 +: 8]),
      .d (sub_slice[(BYTES_PER_CYCLE-1-b)*8 +: 8])
    );
  end

  // Next-state, counter and in-place slice write-back.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    if (abort) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_d = in_data;
            cnt_d  = '0;
            st_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              data_d[(NSLICE-1-k)*SLICE_W +: SLICE_W] = sub_slice;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last_slice) begin
            cnt_d = '0;
            st_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            st_d = ST_IDLE;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State, datapath and status flags, all registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      in_ready  <= (st_d == ST_IDLE);
      out_valid <= (st_d == ST_DONE);
      busy      <= (st_d != ST_IDLE);
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: three instances (4/8/16 lookups per cycle) against a GF(2^8) S-box model.
module tb_aes_inv_sub_bytes;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         abort;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic [2:0]   ir, ov, bz;
  logic [127:0] od [3];

  int checks = 0;
  int errors = 0;
  int exp_lat [3] = '{4, 2, 1};

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
  aes_inv_sub_bytes #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

  // ---------------- reference model: S-box from GF(2^8) inverse + affine map ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] v = gf_inv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = fwd_tab[s[127-8*b -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = inv_tab[s[127-8*b -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one block on all instances, then wait for every out_valid and check latency and data.
  task automatic accept_and_wait(input logic [127:0] din, input logic [127:0] exp);
    int lat [3];
    int cyc;
    lat = '{0, 0, 0};
    cyc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~din;
    while (ov != 3'b111 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 3; k++) if (ov[k] && lat[k] == 0) lat[k] = cyc;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("latency_%0d", k), 128'(lat[k]), 128'(exp_lat[k]));
      check($sformatf("data_%0d", k), od[k], exp);
    end
  endtask

  // Pulse out_ready for one cycle and check every instance is back in IDLE.
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_in_ready", 128'(ir), 128'(3'b111));
    check("ret_out_valid", 128'(ov), 128'(3'b000));
    check("ret_busy", 128'(bz), 128'(3'b000));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [127:0] d, keep;
    reset_n   = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    #22;
    check("rst_in_ready", 128'(ir), 128'(3'b111));
    check("rst_out_valid", 128'(ov), 128'(3'b000));
    check("rst_busy", 128'(bz), 128'(3'b000));
    check("rst_out_data", od[0], 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // FIPS-197 vector
    accept_and_wait(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
    release_out();

    // Constant-byte blocks
    accept_and_wait({16{8'h00}}, {16{8'h52}});
    release_out();
    accept_and_wait({16{8'h16}}, {16{8'hff}});
    release_out();
    accept_and_wait({16{8'hed}}, {16{8'h53}});
    release_out();

    // Backpressure: hold DONE for 10 cycles while offering new input
    d = rand128();
    accept_and_wait(d, inv_state(d));
    keep = inv_state(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rand128();
      @(posedge clk); #1;
      check("bp_out_data", od[0], keep);
      check("bp_out_valid", 128'(ov[0]), 128'(1'b1));
      check("bp_in_ready", 128'(ir[0]), 128'(1'b0));
    end
    in_valid = 1'b0;
    release_out();

    // Abort on the second BUSY cycle, with in_valid asserted in the abort cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand128();
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_in_ready", 128'(ir), 128'(3'b111));
    check("abort_busy", 128'(bz), 128'(3'b000));
    check("abort_out_valid", 128'(ov[0]), 128'(1'b0));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", 128'(ov), 128'(3'b000));
    end
    accept_and_wait({16{8'h63}}, {16{8'h00}});
    release_out();

    // Asynchronous reset mid-block
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(ov), 128'(3'b000));
    check("arst_in_ready", 128'(ir), 128'(3'b111));
    check("arst_busy", 128'(bz), 128'(3'b000));
    check("arst_out_data", od[0], 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    d = rand128();
    accept_and_wait(d, inv_state(d));
    release_out();

    // Random direct blocks
    for (int i = 0; i < 20; i++) begin
      d = rand128();
      accept_and_wait(d, inv_state(d));
      release_out();
    end

    // Round trip: forward S-box in the model, inverse in the DUTs
    for (int i = 0; i < 1000; i++) begin
      d = rand128();
      accept_and_wait(fwd_state(d), d);
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_bytes.md
# aes_inv_sub_bytes

Multi-cycle inverse SubBytes unit for the AES-128 decrypt datapath. It accepts one 128-bit state and replaces every byte with its inverse S-box value. The work is spread over several cycles using a small number of inverse S-box lookups, so a full 16-lookup array is not needed. It sits between InvShiftRows and AddRoundKey in the decrypt round and mirrors the forward S-box used by the encrypt path.

## Interface
- BYTES_PER_CYCLE, 4, inverse S-box lookups per cycle; legal values are 4, 8 and 16. NSLICE = 16/BYTES_PER_CYCLE.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- abort  input  1  synchronous; drops any block in flight and returns to IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a new state this cycle.
- in_data  input  128  state to transform; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream takes out_data this cycle.
- out_data  output  128  inverse-substituted state; same byte order as in_data.
- busy  output  1  high in BUSY or DONE.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: state_q[127:0], slice counter cnt_q with width clog2(NSLICE) (minimum 1 bit).
- IDLE:
  - in_ready = 1.
  - On in_valid: state_q <= in_data, cnt_q <= 0, next state BUSY.
- BUSY:
  - Each cycle, slice cnt_q (bytes cnt_q*BPC .. cnt_q*BPC+BPC-1, MSB-first) goes through the inverse S-box and is written back into state_q in place. All other bytes hold.
  - cnt_q increments each cycle. When the last slice (cnt_q == NSLICE-1) is written, next state is DONE.
- DONE:
  - out_valid = 1; out_data = state_q, held stable.
  - On out_ready: next state IDLE. out_data keeps its value but is meaningless while out_valid = 0.
- in_ready is high only in IDLE. There is no overlap of handshakes, so no accept is possible in DONE even when out_ready is high.
- abort has priority over every transition. The next state is IDLE and cnt_q <= 0. state_q is not cleared. in_valid in the abort cycle is ignored.
- out_valid, once asserted, stays high until out_ready or abort. out_data must not change while out_valid is high.
- in_data is sampled only at the accept edge. Changes to it afterwards have no effect.

## Timing
- Reset values:
  - state = IDLE, cnt_q = 0, state_q = 0.
  - Outputs: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
- Accept at edge E. Slices are written at edges E+1 .. E+NSLICE. out_valid is high after edge E+NSLICE.
  - Latency in clock cycles is NSLICE: 4 for BPC=4, 2 for BPC=8, 1 for BPC=16.
- With out_ready held high, the minimum block period is NSLICE+2 cycles (6 for BPC=4).
- in_ready, out_valid and busy are decoded from registered state only. They have no combinational path from any input.
- Asserting reset_n low mid-block forces the reset values immediately, without waiting for a clock edge. No partial result is ever flagged valid.

## Structure
- aes_pkg (shared):
  - AES_BLOCK_W = 128.
  - Enum typedef for the FSM states (IDLE, BUSY, DONE).
  - Function returning NSLICE.
- Sub-module aes_inv_sbox: purely combinational 8-bit ROM with ports a (in) and d (out), implementing the FIPS-197 inverse S-box. Instantiate it BYTES_PER_CYCLE times via generate.
- Slice byte select: a mux indexed by cnt_q; no barrel shifting of state_q.

## Test plan
- FIPS-197 vector: in_data = 128'h637c777bf26b6fc53001672bfed7ab76 -> out_data = 128'h000102030405060708090a0b0c0d0e0f, with out_valid exactly 4 cycles after accept (BPC=4).
- Constant bytes: in_data all 0x00 -> out_data all 0x52; in_data all 0x16 -> out_data all 0xff; in_data all 0xed -> out_data all 0x53.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid. Check out_data is stable, in_ready = 0 and in_valid is ignored; then pulse out_ready and check return to IDLE in 1 cycle.
- abort asserted on the 2nd BUSY cycle -> IDLE next cycle, out_valid never rises. The next block (all 0x63) returns all 0x00.
- reset_n pulsed low mid-BUSY -> out_valid = 0 and in_ready = 1 without a clock edge. The following block completes normally.
- Round trip: 1000 random states through the forward aes_sbox byte-wise, then this block, for each of BPC = 4, 8 and 16 -> output equals the original state, with latency 4, 2 and 1 cycles respectively.
